// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm
//   Multi-cycle sequencer for the single-issue RV32 core. Walks each
//   instruction through FETCH/DECODE/EXEC/MEM/WB, owns the PC, the retired
//   instruction counter, the memory-wait timeout and the halting trap state.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   0     | FETCH  : imem_req high, wait for imem_ack (timeout -> TRAP 1)
//   1     | DECODE : check decoder verdict, latch instruction class
//   2     | EXEC   : alu_en high, resolve branch/jump target or mem address
//   3     | MEM    : dmem_req high, wait for dmem_ack (timeout -> TRAP 2)
//   4     | WB     : register write strobe, PC update, retire
//   7     | TRAP   : halted, all strobes low, left only through reset
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   imem_ack, dmem_ack    memory handshakes
//   dec_valid, dec_*      decoder verdict and one-hot instruction class
//   br_taken, alu_result  branch condition and ALU output (EXEC only)
//   pc                    current instruction address
//   imem_req, ir_we       fetch request, instruction register load
//   alu_en                ALU operands/result valid
//   dmem_req, dmem_we     data request, store(1)/load(0)
//   rf_we, rf_wsel        write strobe, source 00 ALU / 01 mem / 10 PC+4
//   state                 FSM state code
//   instret               retired instruction count
//   trap, trap_cause      halted flag, 0 illegal/1 imem/2 dmem/3 misaligned

module core_ctrl_fsm #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 16,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             dec_valid,
    input  logic             dec_alu,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             dec_jump,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  pc,
    output logic             imem_req,
    output logic             ir_we,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [1:0] C_ILLEGAL = 2'd0;
    localparam logic [1:0] C_IMEM_TO = 2'd1;
    localparam logic [1:0] C_DMEM_TO = 2'd2;
    localparam logic [1:0] C_MISALGN = 2'd3;

    // class vector bit positions
    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_BR  = 3;
    localparam int K_JMP = 4;

    localparam int              WCNT_W    = $clog2(TIMEOUT + 1);
    // counter value on the last permitted un-acked cycle
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    logic [2:0]        state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   target_q;
    logic              taken_q;
    logic [CNT_W-1:0]  instret_q;
    logic              trap_q;
    logic [1:0]        cause_q;
    logic [WCNT_W-1:0] wait_cnt;
    logic [4:0]        cls_q;
    logic [4:0]        dec_cls;
    logic              redirect;

    assign dec_cls  = {dec_jump, dec_branch, dec_store, dec_load, dec_alu};
    assign redirect = (cls_q[K_BR] && br_taken) || cls_q[K_JMP];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            target_q  <= '0;
            taken_q   <= 1'b0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= C_ILLEGAL;
            wait_cnt  <= '0;
            cls_q     <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // an ack on the expiry cycle still counts as a normal fetch
                    if (imem_ack) begin
                        state_q  <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q  <= S_TRAP;
                        trap_q   <= 1'b1;
                        cause_q  <= C_IMEM_TO;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!dec_valid || !$onehot(dec_cls)) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= C_ILLEGAL;
                    end else begin
                        cls_q   <= dec_cls;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (redirect) begin
                        if (alu_result[1:0] != 2'b00) begin
                            state_q <= S_TRAP;
                            trap_q  <= 1'b1;
                            cause_q <= C_MISALGN;
                        end else begin
                            target_q <= alu_result;
                            taken_q  <= 1'b1;
                            state_q  <= S_WB;
                        end
                    end else if (cls_q[K_LD] || cls_q[K_ST]) begin
                        // data address held for the whole MEM handshake
                        target_q <= alu_result;
                        state_q  <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state_q  <= S_WB;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q  <= S_TRAP;
                        trap_q   <= 1'b1;
                        cause_q  <= C_DMEM_TO;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_WB: begin
                    pc_q      <= taken_q ? target_q : pc_q + XLEN'(4);
                    taken_q   <= 1'b0;
                    instret_q <= instret_q + CNT_W'(1);
                    state_q   <= S_FETCH;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    // unused encodings halt rather than run from an unknown context
                    state_q <= S_TRAP;
                    trap_q  <= 1'b1;
                    cause_q <= C_ILLEGAL;
                end
            endcase
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign ir_we      = (state_q == S_FETCH) && imem_ack;
    assign alu_en     = (state_q == S_EXEC);
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && cls_q[K_ST];
    assign rf_we      = (state_q == S_WB) && (cls_q[K_ALU] || cls_q[K_LD] || cls_q[K_JMP]);
    assign rf_wsel    = (state_q != S_WB) ? 2'b00 :
                        cls_q[K_LD]       ? 2'b01 :
                        cls_q[K_JMP]      ? 2'b10 : 2'b00;
    assign pc         = pc_q;
    assign state      = state_q;
    assign instret    = instret_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule
